// File: rtl/burst_copy_writer_if.sv
// rtl/burst_copy_writer_if.sv - Avalon-MM burst write master signal bundle
interface burst_copy_writer_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BURST_WIDTH   = 4
);
  logic [ADDRESS_WIDTH-1:0]  master_address;
  logic                      master_write;
  logic [DATA_WIDTH-1:0]     master_writedata;
  logic [BURST_WIDTH-1:0]    master_burstcount;
  logic [DATA_WIDTH/8-1:0]   master_byteenable;
  logic                      master_waitrequest;

  modport master (
    output master_address,
    output master_write,
    output master_writedata,
    output master_burstcount,
    output master_byteenable,
    input  master_waitrequest
  );

  modport slave (
    input  master_address,
    input  master_write,
    input  master_writedata,
    input  master_burstcount,
    input  master_byteenable,
    output master_waitrequest
  );
endinterface

// File: rtl/burst_copy_writer.sv
// rtl/burst_copy_writer.sv - drains bursts from the burst reader FIFO and writes them as Avalon-MM bursts
module burst_copy_writer #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BURST_COUNT   = 8,
  parameter int BURST_WIDTH   = 4,
  parameter int LENGTH_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_go,
  input  logic [ADDRESS_WIDTH-1:0] cmd_dst_base,
  input  logic [LENGTH_WIDTH-1:0]  cmd_num_bursts,
  output logic                     cmd_busy,
  output logic                     cmd_done,
  output logic                     rd_start,
  input  logic                     rd_done,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_read,
  burst_copy_writer_if.master      avm
);

  localparam int BEAT_WIDTH = $clog2(BURST_COUNT + 1);
  localparam logic [ADDRESS_WIDTH-1:0] BURST_BYTES = ADDRESS_WIDTH'(BURST_COUNT * (DATA_WIDTH / 8));
  localparam logic [BEAT_WIDTH-1:0]    LAST_BEAT   = BEAT_WIDTH'(BURST_COUNT - 1);
  localparam logic [BEAT_WIDTH-1:0]    ONE_BEAT    = BEAT_WIDTH'(1);
  localparam logic [LENGTH_WIDTH-1:0]  ONE_LEN     = LENGTH_WIDTH'(1);
  localparam logic [BURST_WIDTH-1:0]   BURST_LEN   = BURST_WIDTH'(BURST_COUNT);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RD_WAIT    = 2'd1,
    WR_BURST   = 2'd2,
    RD_RELEASE = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic                       cmd_busy_q, cmd_busy_d;
  logic                       cmd_done_q, cmd_done_d;
  logic                       rd_start_q, rd_start_d;
  logic                       master_write_q, master_write_d;
  logic [ADDRESS_WIDTH-1:0]   address_q, address_d;
  logic [BURST_WIDTH-1:0]     burstcount_q, burstcount_d;
  logic [BEAT_WIDTH-1:0]      beat_q, beat_d;
  logic [LENGTH_WIDTH-1:0]    remaining_q, remaining_d;
  logic                       beat_accept;

  // One FIFO pop per accepted beat keeps the show-ahead head aligned with writedata.
  assign beat_accept            = master_write_q & ~avm.master_waitrequest;
  assign rd_read                = beat_accept;
  assign cmd_busy               = cmd_busy_q;
  assign cmd_done               = cmd_done_q;
  assign rd_start               = rd_start_q;
  assign avm.master_address     = address_q;
  assign avm.master_write       = master_write_q;
  assign avm.master_writedata   = rd_data;
  assign avm.master_burstcount  = burstcount_q;
  assign avm.master_byteenable  = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cmd_busy_q     <= 1'b0;
      cmd_done_q     <= 1'b0;
      rd_start_q     <= 1'b0;
      master_write_q <= 1'b0;
      address_q      <= '0;
      burstcount_q   <= '0;
      beat_q         <= '0;
      remaining_q    <= '0;
    end else begin
      state_q        <= state_d;
      cmd_busy_q     <= cmd_busy_d;
      cmd_done_q     <= cmd_done_d;
      rd_start_q     <= rd_start_d;
      master_write_q <= master_write_d;
      address_q      <= address_d;
      burstcount_q   <= burstcount_d;
      beat_q         <= beat_d;
      remaining_q    <= remaining_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cmd_busy_d     = cmd_busy_q;
    cmd_done_d     = 1'b0;
    rd_start_d     = rd_start_q;
    master_write_d = master_write_q;
    address_d      = address_q;
    burstcount_d   = burstcount_q;
    beat_d         = beat_q;
    remaining_d    = remaining_q;

    case (state_q)
      IDLE: begin
        if (cmd_go) begin
          if (cmd_num_bursts == '0) begin
            cmd_done_d = 1'b1;
          end else begin
            address_d   = cmd_dst_base;
            remaining_d = cmd_num_bursts;
            cmd_busy_d  = 1'b1;
            rd_start_d  = 1'b1;
            state_d     = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        if (rd_done) begin
          rd_start_d     = 1'b0;
          master_write_d = 1'b1;
          burstcount_d   = BURST_LEN;
          beat_d         = '0;
          state_d        = WR_BURST;
        end
      end

      WR_BURST: begin
        if (beat_accept) begin
          if (beat_q == LAST_BEAT) begin
            master_write_d = 1'b0;
            remaining_d    = remaining_q - ONE_LEN;
            state_d        = RD_RELEASE;
          end else begin
            beat_d = beat_q + ONE_BEAT;
          end
        end
      end

      RD_RELEASE: begin
        // The reader must be back in its start state before it can take another ctrl_start.
        if (!rd_done) begin
          if (remaining_q != '0) begin
            address_d  = address_q + BURST_BYTES;
            rd_start_d = 1'b1;
            state_d    = RD_WAIT;
          end else begin
            cmd_done_d = 1'b1;
            cmd_busy_d = 1'b0;
            state_d    = IDLE;
          end
        end
      end

      default: begin
        state_d        = IDLE;
        cmd_busy_d     = 1'b0;
        rd_start_d     = 1'b0;
        master_write_d = 1'b0;
        address_d      = '0;
        burstcount_d   = '0;
        beat_d         = '0;
        remaining_d    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_burst_copy_writer.sv
// tb/tb_burst_copy_writer.sv - self-checking bench for burst_copy_writer with a burst reader model
module tb_burst_copy_writer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BC = 8;
  localparam int BW = 4;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_go = 1'b0;
  logic [AW-1:0] cmd_dst_base = '0;
  logic [LW-1:0] cmd_num_bursts = '0;
  logic          cmd_busy, cmd_done, rd_start, rd_read;
  logic          rd_done = 1'b0;
  logic [DW-1:0] rd_data = '0;

  burst_copy_writer_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) avm ();

  burst_copy_writer #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BURST_COUNT(BC), .BURST_WIDTH(BW), .LENGTH_WIDTH(LW)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_go(cmd_go), .cmd_dst_base(cmd_dst_base), .cmd_num_bursts(cmd_num_bursts),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done),
    .rd_start(rd_start), .rd_done(rd_done), .rd_data(rd_data), .rd_read(rd_read),
    .avm(avm)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  bc;
  } beat_t;

  beat_t       got[$];
  logic [31:0] exp_data[$];
  logic [31:0] rfifo[$];

  // Observation counters and timestamps, written only in the sampling phase.
  int cyc = 0, n_acc = 0, n_start = 0, n_done = 0, n_wcyc = 0, n_busy = 0;
  int t_go = -1, t_rise = -1, t_first_w = -1, t_first = -1, t_last8 = -1, t_fall = -1, t_done = -1;
  logic prev_rd_done = 0, prev_write = 0, prev_rd_start = 0;
  logic [31:0] prev_addr = 0;
  logic [3:0]  prev_bc = 0;

  int wait_mode = 0, stall_cnt = 0, beat_idx = 0;
  int stall_tab[BC] = '{2, 0, 0, 2, 0, 0, 0, 1};
  int r_state = 0, r_lat = 0;
  bit seq_words = 1;
  logic [31:0] next_word = 1, w;
  bit pend_accept = 0, pend_start = 0, pend_reset = 1, acc;

  always @(negedge clk) begin
    // Reader model: reacts to what the DUT did at the posedge just passed.
    if (pend_reset) begin
      rfifo.delete();
      r_state = 0;
      rd_done = 1'b0;
      beat_idx = 0;
      stall_cnt = 0;
    end else begin
      if (pend_accept && rfifo.size() > 0) void'(rfifo.pop_front());
      case (r_state)
        0: if (pend_start) begin r_lat = $urandom_range(0, 3); r_state = 1; end
        1: begin
          if (r_lat == 0) begin
            for (int k = 0; k < BC; k++) begin
              w = seq_words ? next_word : $urandom;
              next_word++;
              rfifo.push_back(w);
              exp_data.push_back(w);
            end
            rd_done = 1'b1;
            r_state = 2;
          end else begin
            r_lat--;
          end
        end
        2: if (rfifo.size() == 0) begin rd_done = 1'b0; r_state = 0; end
        default: r_state = 0;
      endcase
    end
    rd_data = (rfifo.size() > 0) ? rfifo[0] : '0;

    if (avm.master_write && wait_mode == 1 && stall_cnt < stall_tab[beat_idx]) begin
      avm.master_waitrequest = 1'b1;
      stall_cnt++;
    end else if (avm.master_write && wait_mode == 2) begin
      avm.master_waitrequest = ($urandom_range(0, 2) == 0);
    end else begin
      avm.master_waitrequest = 1'b0;
    end

    #1;
    cyc++;
    acc = avm.master_write && !avm.master_waitrequest;
    check("rd_read_vs_accept", rd_read, acc);
    check("writedata_passthru", avm.master_writedata, rd_data);
    check("byteenable", avm.master_byteenable, 4'hF);
    if (rd_read) check("pop_before_ready", rd_done, 1'b1);
    if (avm.master_write && prev_write) begin
      check("addr_stable", avm.master_address, prev_addr);
      check("bc_stable", avm.master_burstcount, prev_bc);
    end
    if (acc) begin
      got.push_back('{avm.master_address, avm.master_writedata, avm.master_burstcount});
      n_acc++;
      if (t_first < 0) t_first = cyc;
      if (n_acc == BC) t_last8 = cyc;
      beat_idx = (beat_idx + 1) % BC;
      stall_cnt = 0;
    end
    if (avm.master_write) begin
      n_wcyc++;
      if (t_first_w < 0) t_first_w = cyc;
    end
    if (rd_done && !prev_rd_done && t_rise < 0) t_rise = cyc;
    if (!rd_done && prev_rd_done) t_fall = cyc;
    if (rd_start && !prev_rd_start) n_start++;
    if (cmd_done) begin n_done++; t_done = cyc; end
    if (cmd_busy) n_busy++;
    if (cmd_go && !cmd_busy && t_go < 0) t_go = cyc;
    prev_rd_done  = rd_done;
    prev_write    = avm.master_write;
    prev_rd_start = rd_start;
    prev_addr     = avm.master_address;
    prev_bc       = avm.master_burstcount;
    pend_accept   = acc;
    pend_start    = rd_start && (r_state == 0);
    pend_reset    = reset;
  end

  task automatic clear_stats(input int mode, input bit seq);
    got.delete();
    exp_data.delete();
    n_acc = 0; n_start = 0; n_done = 0; n_wcyc = 0; n_busy = 0;
    t_go = -1; t_rise = -1; t_first_w = -1; t_first = -1; t_last8 = -1; t_fall = -1; t_done = -1;
    wait_mode = mode;
    seq_words = seq;
    next_word = 1;
  endtask

  // Called at a negedge; issues one command and checks it against the address/data model.
  task automatic run_cmd(input string name, input logic [31:0] dst, input int num, input int mode,
                         input bit go_busy, input bit seq, input logic [31:0] exp_last);
    int          exp_beats;
    bit          pulsed;
    logic [31:0] ea, ed;
    exp_beats = num * BC;
    pulsed = 0;
    clear_stats(mode, seq);
    cmd_dst_base   = dst;
    cmd_num_bursts = LW'(num);
    cmd_go         = 1'b1;
    for (int i = 0; i < 4000 && n_done == 0; i++) begin
      @(negedge clk);
      cmd_go = 1'b0;
      if (go_busy && !pulsed && n_acc >= 2) begin
        cmd_go = 1'b1;
        cmd_dst_base = 32'h1234_0000;
        cmd_num_bursts = 16'd5;
        pulsed = 1;
      end
    end
    cmd_go = 1'b0;
    repeat (4) @(negedge clk);

    check({name, "/done_count"}, n_done, 1);
    check({name, "/rd_start_count"}, n_start, num);
    check({name, "/beats"}, got.size(), exp_beats);
    check({name, "/busy_cycles"}, n_busy, t_done - t_go - 1);
    for (int i = 0; i < got.size() && i < exp_beats; i++) begin
      ea = dst + 32'((i / BC) * BC * (DW / 8));
      ed = (i < exp_data.size()) ? exp_data[i] : 32'hDEAD_BEEF;
      check($sformatf("%s/addr[%0d]", name, i), got[i].addr, ea);
      check($sformatf("%s/data[%0d]", name, i), got[i].data, ed);
      check($sformatf("%s/bc[%0d]", name, i), got[i].bc, BC);
    end
    if (num > 0) begin
      if (got.size() > 0) check({name, "/last_addr"}, got[got.size()-1].addr, exp_last);
      check({name, "/write_after_rd_done"}, t_first_w - t_rise, 1);
      check({name, "/done_after_rd_release"}, t_done - t_fall, 1);
      if (mode == 0) begin
        check({name, "/back_to_back"}, t_last8 - t_first, BC - 1);
        check({name, "/write_cycles"}, n_wcyc, exp_beats);
      end
      if (mode == 1) check({name, "/write_cycles_stalled"}, n_wcyc, num * (BC + 5));
    end else begin
      check({name, "/zero_done_latency"}, t_done - t_go, 1);
      check({name, "/zero_no_write"}, n_wcyc, 0);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] dst;
    int          num;
    int          mode;
    bit          go_busy;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[5];
  logic [31:0] rdst;
  int rnum;

  initial begin
    vecs[0] = '{"single",     32'h0000_1000, 1, 0, 1'b0, 32'h0000_1000};
    vecs[1] = '{"stalls",     32'h0000_1000, 1, 1, 1'b0, 32'h0000_1000};
    vecs[2] = '{"multi",      32'h0000_2000, 3, 0, 1'b0, 32'h0000_2040};
    vecs[3] = '{"zero",       32'h0000_5000, 0, 0, 1'b0, 32'h0000_0000};
    vecs[4] = '{"wrap_gobsy", 32'hFFFF_FFE0, 2, 1, 1'b1, 32'h0000_0000};

    avm.master_waitrequest = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset/cmd_busy", cmd_busy, 0);
    check("reset/cmd_done", cmd_done, 0);
    check("reset/rd_start", rd_start, 0);
    check("reset/master_write", avm.master_write, 0);
    check("reset/master_address", avm.master_address, 0);
    check("reset/master_burstcount", avm.master_burstcount, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++)
      run_cmd(vecs[v].name, vecs[v].dst, vecs[v].num, vecs[v].mode, vecs[v].go_busy, 1'b1, vecs[v].exp_last);

    // Reset while the fifth beat of the first burst has just been accepted.
    clear_stats(0, 1'b1);
    cmd_dst_base   = 32'h0000_3000;
    cmd_num_bursts = 16'd2;
    cmd_go         = 1'b1;
    for (int i = 0; i < 200 && n_acc < 5; i++) begin
      @(negedge clk);
      cmd_go = 1'b0;
    end
    check("midreset/beats_before", n_acc, 5);
    reset = 1'b1;
    @(negedge clk);
    check("midreset/master_write", avm.master_write, 0);
    check("midreset/rd_start", rd_start, 0);
    check("midreset/cmd_busy", cmd_busy, 0);
    check("midreset/master_address", avm.master_address, 0);
    check("midreset/master_burstcount", avm.master_burstcount, 0);
    reset = 1'b0;
    @(negedge clk);
    run_cmd("after_reset", 32'h0000_4000, 2, 0, 1'b0, 1'b1, 32'h0000_4020);

    for (int r = 0; r < 8; r++) begin
      rdst = $urandom;
      rnum = $urandom_range(0, 3);
      run_cmd($sformatf("rand%0d", r), rdst, rnum, 2, 1'b0, 1'b0,
              rdst + 32'(((rnum > 0) ? rnum - 1 : 0) * BC * (DW / 8)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
